drt_scanner: RTL and testbench

Wishbone master that walks the device ROM table (DRT) and locates the first device whose ID matches a requested, masked value. It reads the DRT header, iterates the device entries, and reports the matching entry's index, info, memory offset and size. It sits between the interconnect's DRT slave port and host-side or boot logic that needs to discover peripheral base addresses at run time. It is the only sequencer of DRT reads in the system.

---
 rtl/drt_scanner.sv | 197 +++++++++++++++++++
 tb/tb_drt_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drt_scanner.sv
// drt_scanner: Wishbone master that walks the device ROM table and reports
// the first entry whose masked ID matches the requested value.
//
// state     | meaning
// S_IDLE    | waiting for start; results held
// S_RD_NUM  | reading header word 1 (device count)
// S_CHK_NUM | validating the device count
// S_RD_ID   | reading ID word of entry idx
// S_CMP     | masked compare of the fetched ID
// S_RD_INFO | reading entry word 1
// S_RD_OFF  | reading entry word 2
// S_RD_SIZE | reading entry word 3, then reporting the match
// S_DONE    | done pulse, busy still high
module drt_scanner #(
    parameter int HEADER_WORDS = 8,
    parameter int DEV_WORDS    = 8,
    parameter int MAX_DEVICES  = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] match_id,
    input  logic [31:0] match_mask,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        error,
    output logic [31:0] num_devices,
    output logic [7:0]  dev_index,
    output logic [31:0] dev_info,
    output logic [31:0] dev_mem_off,
    output logic [31:0] dev_size,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_NUM, S_CHK_NUM, S_RD_ID, S_CMP,
        S_RD_INFO, S_RD_OFF, S_RD_SIZE, S_DONE
    } state_t;

    state_t        state;
    logic [7:0]    idx;
    logic [31:0]   id_q;
    logic [31:0]   mask_q;
    logic [31:0]   rd_id;
    logic [TW-1:0] tmr;
    logic          is_read;
    logic [31:0]   entry_base;
    logic [31:0]   rd_adr;

    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hF;

    always_comb begin
        entry_base = 32'(HEADER_WORDS) + 32'(idx) * 32'(DEV_WORDS);
        is_read    = 1'b1;
        rd_adr     = entry_base;
        case (state)
            S_RD_NUM:  rd_adr = 32'd1;
            S_RD_ID:   rd_adr = entry_base;
            S_RD_INFO: rd_adr = entry_base + 32'd1;
            S_RD_OFF:  rd_adr = entry_base + 32'd2;
            S_RD_SIZE: rd_adr = entry_base + 32'd3;
            default:   is_read = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            id_q        <= '0;
            mask_q      <= '0;
            rd_id       <= '0;
            tmr         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            error       <= 1'b0;
            num_devices <= '0;
            dev_index   <= '0;
            dev_info    <= '0;
            dev_mem_off <= '0;
            dev_size    <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_adr_o   <= '0;
        end else begin
            done <= 1'b0;
            if (is_read) begin
                // A new request waits for the previous ack to clear; that wait is untimed.
                if (!wbm_stb_o) begin
                    if (!wbm_ack_i) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_adr_o <= rd_adr;
                        tmr       <= TW'(TIMEOUT - 1);
                    end
                end else if (wbm_ack_i) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    case (state)
                        S_RD_NUM: begin
                            num_devices <= wbm_dat_i;
                            state       <= S_CHK_NUM;
                        end
                        S_RD_ID: begin
                            rd_id <= wbm_dat_i;
                            state <= S_CMP;
                        end
                        S_RD_INFO: begin
                            dev_info <= wbm_dat_i;
                            state    <= S_RD_OFF;
                        end
                        S_RD_OFF: begin
                            dev_mem_off <= wbm_dat_i;
                            state       <= S_RD_SIZE;
                        end
                        S_RD_SIZE: begin
                            dev_size  <= wbm_dat_i;
                            found     <= 1'b1;
                            dev_index <= idx;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end else if (tmr == '0) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    error     <= 1'b1;
                    found     <= 1'b0;
                    done      <= 1'b1;
                    state     <= S_DONE;
                end else begin
                    tmr <= tmr - 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            id_q        <= match_id;
                            mask_q      <= match_mask;
                            found       <= 1'b0;
                            error       <= 1'b0;
                            num_devices <= '0;
                            dev_index   <= '0;
                            dev_info    <= '0;
                            dev_mem_off <= '0;
                            dev_size    <= '0;
                            idx         <= '0;
                            busy        <= 1'b1;
                            state       <= S_RD_NUM;
                        end
                    end
                    S_CHK_NUM: begin
                        idx <= '0;
                        if (num_devices == 32'd0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (num_devices > 32'(MAX_DEVICES)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_RD_ID;
                        end
                    end
                    S_CMP: begin
                        if (((rd_id ^ id_q) & mask_q) == 32'd0) begin
                            state <= S_RD_INFO;
                        end else if (({24'd0, idx} + 32'd1) == num_devices) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= S_RD_ID;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_drt_scanner.sv
// tb_drt_scanner: drives scans against a Wishbone ROM-table slave model and
// compares results and issued read addresses with a behavioural table walker.
module tb_drt_scanner;
    localparam int HDR = 8;
    localparam int DEVW = 8;
    localparam int MAXD = 16;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] match_id, match_mask;
    logic        busy, done, found, error;
    logic [31:0] num_devices;
    logic [7:0]  dev_index;
    logic [31:0] dev_info, dev_mem_off, dev_size;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;

    always #5 clk = ~clk;

    drt_scanner #(.HEADER_WORDS(HDR), .DEV_WORDS(DEVW), .MAX_DEVICES(MAXD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .match_id(match_id), .match_mask(match_mask),
        .busy(busy), .done(done), .found(found), .error(error), .num_devices(num_devices),
        .dev_index(dev_index), .dev_info(dev_info), .dev_mem_off(dev_mem_off), .dev_size(dev_size),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    // Slave: registered ack, held until stb is seen low (plus optional extra hold).
    logic [31:0] mem [0:255];
    int ack_delay = 0, extra_hold = 0, wcnt = 0, hold = 0;
    bit never_ack = 1'b0;

    always @(posedge clk) begin
        if (wbm_ack_i) begin
            if (!wbm_stb_o) begin
                if (hold > 0) hold <= hold - 1;
                else wbm_ack_i <= 1'b0;
            end
        end else if (wbm_cyc_o && wbm_stb_o && !never_ack) begin
            if (wcnt >= ack_delay) begin
                wbm_ack_i <= 1'b1;
                wbm_dat_i <= mem[wbm_adr_o[7:0]];
                wcnt      <= 0;
                hold      <= extra_hold;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Bus monitor: addresses of issued reads, longest stb run, requests issued over a live ack.
    logic [31:0] addr_q [$];
    int   run_len = 0, max_run = 0, stale_cnt = 0;
    logic prev_stb = 1'b0, prev_ack = 1'b0;

    always @(posedge clk) begin
        if (wbm_stb_o) begin
            if (!prev_stb) begin
                addr_q.push_back(wbm_adr_o);
                if (prev_ack) stale_cnt++;
            end
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        prev_stb = wbm_stb_o;
        prev_ack = wbm_ack_i;
    end

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference walk of the table.
    int          e_addrs [$];
    logic        e_found, e_error;
    logic [31:0] e_idx, e_info, e_off, e_size, e_num;

    task automatic model_scan(input logic [31:0] id, input logic [31:0] mask);
        e_addrs.delete();
        e_found = 0; e_error = 0; e_idx = 0; e_info = 0; e_off = 0; e_size = 0; e_num = 0;
        e_addrs.push_back(1);
        if (never_ack) begin
            e_error = 1;
            return;
        end
        e_num = mem[1];
        if (e_num > MAXD) begin
            e_error = 1;
        end else begin
            for (int i = 0; i < int'(e_num); i++) begin
                int a = HDR + i * DEVW;
                e_addrs.push_back(a);
                if (((mem[a] ^ id) & mask) == 32'd0) begin
                    e_addrs.push_back(a + 1);
                    e_addrs.push_back(a + 2);
                    e_addrs.push_back(a + 3);
                    e_found = 1;
                    e_idx   = i;
                    e_info  = mem[a + 1];
                    e_off   = mem[a + 2];
                    e_size  = mem[a + 3];
                    break;
                end
            end
        end
    endtask

    task automatic run_scan(input string tag, input logic [31:0] id, input logic [31:0] mask,
                            input bit chk_lat);
        int cnt;
        bit seen;
        int n;
        model_scan(id, mask);
        @(negedge clk);
        addr_q.delete();
        max_run = 0;
        stale_cnt = 0;
        start = 1'b1; match_id = id; match_mask = mask;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_on"}, busy, 1);
        cnt = 1;
        seen = 0;
        while (!seen && cnt < 3000) begin
            if (done) begin
                seen = 1;
            end else begin
                // stray starts and request changes mid-scan must be ignored
                start = ($urandom_range(0, 3) == 0);
                match_id = $urandom;
                match_mask = $urandom;
                @(negedge clk);
                cnt++;
            end
        end
        chk({tag, ".done_seen"}, seen, 1);
        chk({tag, ".found"}, found, e_found);
        chk({tag, ".error"}, error, e_error);
        chk({tag, ".num"}, num_devices, e_num);
        chk({tag, ".index"}, dev_index, e_idx);
        chk({tag, ".info"}, dev_info, e_info);
        chk({tag, ".off"}, dev_mem_off, e_off);
        chk({tag, ".size"}, dev_size, e_size);
        chk({tag, ".busy_at_done"}, busy, 1);
        if (chk_lat) chk({tag, ".latency"}, cnt <= 4 * (2 + int'(e_num) + 3) + 4, 1);
        // start coinciding with done is dropped
        start = 1'b1;
        match_id = $urandom;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_after"}, busy, 0);
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".found_held"}, found, e_found);
        chk({tag, ".stale"}, stale_cnt, 0);
        chk({tag, ".nreads"}, addr_q.size(), e_addrs.size());
        n = (addr_q.size() < e_addrs.size()) ? addr_q.size() : e_addrs.size();
        for (int i = 0; i < n; i++) chk({tag, ".adr"}, addr_q[i], e_addrs[i]);
    endtask

    task automatic load_table();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[1]  = 32'd2;
        mem[8]  = 32'h0001_0001;
        mem[16] = 32'h0002_0002;
        mem[17] = 32'h0000_0001;
        mem[18] = 32'h0100_0000;
        mem[19] = 32'h0000_0100;
    endtask

    initial begin
        int k;
        bit hit;
        logic [31:0] ids [4];
        rst = 1'b1; start = 1'b0; match_id = '0; match_mask = '0;
        load_table();
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.bus", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("rst.adr", wbm_adr_o, 0);
        chk("rst.flags", {found, error}, 0);
        chk("const.we", wbm_we_o, 0);
        chk("const.sel", wbm_sel_o, 4'hF);
        rst = 1'b0;

        run_scan("exact", 32'h0002_0002, 32'hFFFF_FFFF, 1);
        run_scan("miss", 32'h0003_0003, 32'hFFFF_FFFF, 1);
        run_scan("masked", 32'h0000_0002, 32'h0000_FFFF, 1);
        mem[1] = 32'd0;
        run_scan("num0", 32'h0002_0002, 32'hFFFF_FFFF, 1);
        mem[1] = 32'd17;
        run_scan("num17", 32'h0002_0002, 32'hFFFF_FFFF, 1);
        mem[1] = 32'd16;
        run_scan("num16", 32'h0002_0002, 32'hFFFF_FFFF, 1);
        mem[1] = 32'd2;

        never_ack = 1'b1;
        run_scan("timeout", 32'h0002_0002, 32'hFFFF_FFFF, 0);
        chk("timeout.stb_cycles", max_run, TMO);
        chk("timeout.bus_idle", {wbm_cyc_o, wbm_stb_o}, 0);
        never_ack = 1'b0;

        // reset in the middle of an entry ID read
        @(negedge clk);
        start = 1'b1; match_id = 32'h0002_0002; match_mask = '1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        hit = 0;
        while (!hit && k < 200) begin
            if (wbm_stb_o && wbm_adr_o == 32'd8) hit = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("midrst.reached_rd_id", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.bus", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("midrst.adr", wbm_adr_o, 0);
        chk("midrst.ctl", {busy, done, found, error}, 0);
        chk("midrst.num", num_devices, 0);
        chk("midrst.dev", dev_index | dev_info | dev_mem_off | dev_size, 0);
        rst = 1'b0;
        run_scan("post_rst", 32'h0002_0002, 32'hFFFF_FFFF, 0);

        extra_hold = 3;
        run_scan("long_ack", 32'h0002_0002, 32'hFFFF_FFFF, 0);
        extra_hold = 0;

        ids[0] = 32'h0001_0001; ids[1] = 32'h0001_0002;
        ids[2] = 32'h0002_0001; ids[3] = 32'h0002_0002;
        for (int r = 0; r < 20; r++) begin
            logic [31:0] m;
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            mem[1] = $urandom_range(0, 18);
            for (int i = 0; i < MAXD; i++) mem[HDR + i * DEVW] = ids[$urandom_range(0, 3)];
            case ($urandom_range(0, 3))
                0: m = 32'hFFFF_FFFF;
                1: m = 32'h0000_FFFF;
                2: m = 32'hFFFF_0000;
                default: m = $urandom;
            endcase
            ack_delay  = $urandom_range(0, 2);
            extra_hold = $urandom_range(0, 3);
            run_scan($sformatf("rnd%0d", r), ids[$urandom_range(0, 3)], m,
                     (ack_delay == 0) && (extra_hold == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
